// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// A single 64-bit accumulator carries the shift-add product or the
// {remainder, quotient} pair; signs are fixed up when HI/LO are written.
module mul_div_unit #(
  parameter int FAST_MUL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [1:0]  op_r;     // bit1: divide, bit0: unsigned
  logic [31:0] a_r, b_r;
  logic [63:0] acc;      // mul: {partial, multiplier}; div: {rem, quotient}
  logic [31:0] opnd;     // multiplicand or divisor magnitude

  logic        launch, finish;
  logic        sgn_in, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        sa, sb;
  logic [32:0] mul_sum;
  logic        div_ok;
  logic [31:0] div_rem;
  logic [63:0] acc_nx;
  logic [63:0] ext_a, ext_b, fprod;
  logic [63:0] result;

  assign launch = (state == IDLE) && start && !op[2];
  assign finish = (state == RUN) && (cnt == 6'd1);
  assign busy   = (state == RUN);

  // Magnitudes of the incoming operands; only MULT/DIV (op[0]=0) are signed.
  // -0x80000000 wraps to 0x80000000, which is exactly 2^31 as unsigned.
  assign sgn_in = !op[0];
  assign neg_a  = sgn_in & a[31];
  assign neg_b  = sgn_in & b[31];
  assign mag_a  = neg_a ? -a : a;
  assign mag_b  = neg_b ? -b : b;

  // Sign of the latched operands, used for the final correction.
  assign sa = !op_r[0] & a_r[31];
  assign sb = !op_r[0] & b_r[31];

  // Full-width signed product for the single-cycle multiply option.
  assign ext_a = {{32{sa}}, a_r};
  assign ext_b = {{32{sb}}, b_r};
  assign fprod = $signed(ext_a) * $signed(ext_b);

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_ok  = acc[63] | (acc[62:31] >= opnd);
    div_rem = acc[62:31] - opnd;
    if (op_r[1])
      acc_nx = div_ok ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_nx = {mul_sum, acc[31:1]};
  end

  // Sign-corrected result as it will land in {hi, lo}; taken from the
  // accumulator after its last step (acc_nx) on the finishing edge.
  always_comb begin
    result = 64'd0;
    if (!op_r[1]) begin
      if (FAST_MUL != 0) result = fprod;
      else               result = (sa ^ sb) ? -acc_nx : acc_nx;
    end else if (b_r == 32'd0) begin
      result = {a_r, 32'hFFFF_FFFF};
    end else begin
      result[63:32] = sa ? -acc_nx[63:32] : acc_nx[63:32];
      result[31:0]  = (sa ^ sb) ? -acc_nx[31:0] : acc_nx[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: launch from IDLE, return on the final count.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = RUN;
      RUN:     if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 6'd0;
      op_r <= 2'd0;
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      acc  <= 64'd0;
      opnd <= 32'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (state == IDLE) begin
        if (start && op == OP_MTHI) hi <= a;
        if (start && op == OP_MTLO) lo <= a;
        if (launch) begin
          op_r <= op[1:0];
          a_r  <= a;
          b_r  <= b;
          cnt  <= (!op[1] && FAST_MUL != 0) ? 6'd1 : 6'd32;
          acc  <= {32'd0, op[1] ? mag_a : mag_b};
          opnd <= op[1] ? mag_b : mag_a;
        end
      end else begin
        cnt <= cnt - 6'd1;
        acc <= acc_nx;
        if (finish) {hi, lo} <= result;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: an iterative instance and a FAST_MUL instance,
// checked against a plain-arithmetic model of HI/LO.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]        start_v;
  logic [2:0]        op_v;
  logic [31:0]       a_v, b_v;
  logic [1:0]        busy_v, done_v;
  logic [1:0][31:0]  hi_v, lo_v;

  int vecs = 0;
  int errs = 0;
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];

  always #5 clk = ~clk;

  mul_div_unit #(.FAST_MUL(0)) u_slow (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v), .a(a_v), .b(b_v),
    .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0]));

  mul_div_unit #(.FAST_MUL(1)) u_fast (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v), .a(a_v), .b(b_v),
    .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {hi, lo} from the architectural definition.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation on unit u; optionally hold start through RUN, or
  // pulse a stray MULT in the middle of the run.
  task automatic do_op(input int u, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit hold, input bit poke);
    logic [63:0] r;
    int n, lat;
    bit stable;
    @(negedge clk);
    start_v[u] = 1'b1; op_v = o; a_v = x; b_v = y;
    @(posedge clk); #1;
    if (o[2]) begin
      start_v[u] = 1'b0;
      if (o == 3'd4) mhi[u] = x;
      if (o == 3'd5) mlo[u] = x;
      chk("mt_busy", busy_v[u], 0);
      chk("mt_done", done_v[u], 0);
      chk("mt_hi", hi_v[u], mhi[u]);
      chk("mt_lo", lo_v[u], mlo[u]);
      return;
    end
    if (!hold) start_v[u] = 1'b0;
    r = ref_res(o, x, y);
    lat = (u == 1 && o < 3'd2) ? 1 : 32;
    n = 0;
    stable = 1'b1;
    while (busy_v[u] && n < 100) begin
      n++;
      if (hi_v[u] !== mhi[u] || lo_v[u] !== mlo[u] || done_v[u] !== 1'b0) stable = 1'b0;
      if (poke && n == 5) begin
        start_v[u] = 1'b1; op_v = 3'd0; a_v = $urandom; b_v = $urandom;
      end
      if (poke && n == 6) start_v[u] = 1'b0;
      @(posedge clk); #1;
    end
    start_v[u] = 1'b0;
    mhi[u] = r[63:32];
    mlo[u] = r[31:0];
    chk("busy_cycles", n, lat);
    chk("run_stable", stable, 1);
    chk("done", done_v[u], 1);
    chk("hi", hi_v[u], mhi[u]);
    chk("lo", lo_v[u], mlo[u]);
    @(posedge clk); #1;
    chk("done_pulse", done_v[u], 0);
    chk("idle_busy", busy_v[u], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int late;
    rst = 1'b0; start_v = 2'b00; op_v = 3'd0; a_v = 32'd0; b_v = 32'd0;
    for (int i = 0; i < 2; i++) begin mhi[i] = 32'd0; mlo[i] = 32'd0; end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
      chk("rst_hi", hi_v[i], 0);
      chk("rst_lo", lo_v[i], 0);
    end
    @(negedge clk); rst = 1'b1;

    do_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu_max_hi", hi_v[0], 32'hFFFF_FFFE);
    do_op(0, 3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    do_op(1, 3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    do_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(0, 3'd3, 32'd100, 32'd7, 1, 0);
    do_op(0, 3'd3, 32'h0000_1234, 32'd0, 0, 0);
    do_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(0, 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    do_op(0, 3'd4, 32'hAAAA_5555, 32'd0, 0, 0);
    do_op(0, 3'd5, 32'h0F0F_0F0F, 32'd0, 0, 0);
    do_op(0, 3'd6, 32'h1111_1111, 32'd0, 0, 0);
    do_op(0, 3'd0, 32'h0001_2345, 32'hFFFE_0001, 0, 1);

    for (int k = 0; k < 40; k++)
      do_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a divide.
    do_op(0, 3'd5, 32'hCAFE_F00D, 32'd0, 0, 0);
    @(negedge clk);
    start_v[0] = 1'b1; op_v = 3'd3; a_v = 32'hDEAD_BEEF; b_v = 32'd3;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_done", done_v[0], 0);
    chk("mid_rst_hi", hi_v[0], 0);
    chk("mid_rst_lo", lo_v[0], 0);
    for (int i = 0; i < 2; i++) begin mhi[i] = 32'd0; mlo[i] = 32'd0; end
    @(negedge clk); rst = 1'b1;
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0] || hi_v[0] != 32'd0 || lo_v[0] != 32'd0) late++;
    end
    chk("no_late_result", late, 0);
    do_op(0, 3'd3, 32'd100, 32'd7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
